// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver.
//   - uart_state_e    : receiver FSM states
//   - OVERSAMPLE      : ticks per bit period
//   - baud_div()      : clk cycles per oversample tick
//   - maj3()          : 2-of-3 majority vote for the mid-bit samples
//   - parity_mismatch : parity check of a data byte against its parity bit
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Integer (truncating) divisor; a result below 1 is a configuration error.
  function automatic int baud_div(input int clock_rate, input int baudrate);
    return clock_rate / (baudrate * OVERSAMPLE);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Returns 1 when the received parity does not match the configured sense.
  function automatic logic parity_mismatch(input logic [7:0] data,
                                           input logic       pbit,
                                           input logic       odd);
    return ((^data) ^ pbit) != odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator.
// Emits a registered one-clk pulse on tick every DIV clks. A high clear
// restarts the period so the next tick lands DIV clks later.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   clear - synchronous restart of the divider
//   tick  - one-clk oversample pulse
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  // A divisor below 1 is illegal; clamp so the hardware still elaborates
  // and ticks every clk rather than never.
  localparam int DIV_EFF = (DIV < 1) ? 1 : DIV;
  localparam int CNT_W   = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_EFF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next-state of the divider counter and tick pulse.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, 16x oversampled, optional parity.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   rx                  - asynchronous serial line (idle high)
//   rx_data[7:0]        - received byte, LSB first on the line
//   rx_valid / rx_ready - output handshake; byte held until accepted
//   frame_err           - stop bit sampled as 0 (qualified by rx_valid)
//   parity_err          - parity mismatch (qualified by rx_valid)
//   overrun             - held byte overwritten before acceptance
//   busy                - receiver is inside a frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int clock_rate = 50000000,
  parameter int baudrate   = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int   DIV     = baud_div(clock_rate, baudrate);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  // Line synchronizer and edge detector.
  logic        sync1_q, rx_s_q, rx_prev_q;
  // Frame engine.
  uart_state_e state_q, state_d;
  logic [3:0]  samp_cnt_q, samp_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  smp_q, smp_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_err_q, par_err_d;
  // Output registers.
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        parity_err_q, parity_err_d;
  logic        overrun_q, overrun_d;
  logic        busy_q, busy_d;

  logic        tick_s;
  logic        start_edge_s;
  logic        clear_s;
  logic        decide_s;
  logic        boundary_s;
  logic        maj_s;
  logic        complete_s;

  assign start_edge_s = rx_prev_q & ~rx_s_q;
  // Only a 1->0 edge seen while idle starts a frame and realigns the timing.
  assign clear_s      = (state_q == ST_IDLE) && start_edge_s;
  assign decide_s     = tick_s && (samp_cnt_q == 4'd9);
  assign boundary_s   = tick_s && (samp_cnt_q == 4'd15);
  // Samples from counts 7 and 8 plus the live sample at count 9.
  assign maj_s        = maj3(smp_q[0], smp_q[1], rx_s_q);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // Two-flop synchronizer plus previous-value flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Sample counter and mid-bit sample capture.
  always_comb begin
    samp_cnt_d = samp_cnt_q;
    smp_d      = smp_q;
    if (clear_s) begin
      samp_cnt_d = 4'd0;
    end else if (tick_s && (state_q != ST_IDLE)) begin
      samp_cnt_d = samp_cnt_q + 4'd1;
      if (samp_cnt_q == 4'd7) begin
        smp_d[0] = rx_s_q;
      end else if (samp_cnt_q == 4'd8) begin
        smp_d[1] = rx_s_q;
      end else begin
        smp_d = smp_q;
      end
    end else begin
      samp_cnt_d = samp_cnt_q;
    end
  end

  // Frame FSM next-state: bit decisions at count 9, state steps at count 15.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    complete_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_d   = ST_START;
          bit_cnt_d = 3'd0;
          par_err_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (decide_s && maj_s) begin
          // Start bit did not hold low: treat as a glitch.
          state_d = ST_IDLE;
        end else if (boundary_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (decide_s) begin
          shift_d = {maj_s, shift_q[7:1]};
        end else if (boundary_s) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (decide_s) begin
          par_err_d = parity_mismatch(shift_q, maj_s, ODD_BIT);
        end else if (boundary_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (decide_s) begin
          // Leave mid-stop so the next start edge is not missed.
          complete_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output holding register and handshake.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    busy_d       = (state_d != ST_IDLE);
    if (complete_s) begin
      rx_data_d    = shift_q;
      rx_valid_d   = 1'b1;
      frame_err_d  = ~maj_s;
      parity_err_d = (PARITY_EN != 0) ? par_err_q : 1'b0;
      // Overrun only if the held byte is not being accepted this cycle.
      overrun_d    = rx_valid_q & ~rx_ready;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d   = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // Frame engine and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      samp_cnt_q   <= 4'd0;
      bit_cnt_q    <= 3'd0;
      smp_q        <= 2'b00;
      shift_q      <= 8'h00;
      par_err_q    <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_cnt_q   <= samp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      smp_q        <= smp_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// Instance 0 uses the default configuration (432 clks/bit, no parity);
// instance 1 uses even parity at 64 clks/bit.
module tb_uart_rx;

  localparam int CLK0 = 50000000;
  localparam int BAUD = 115200;
  localparam int BIT0 = (CLK0 / (BAUD * 16)) * 16;
  localparam int CLK1 = 7372800;
  localparam int BIT1 = (CLK1 / (BAUD * 16)) * 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0, rx_ready0, rx_valid0, frame_err0, parity_err0, overrun0, busy0;
  logic [7:0] rx_data0;
  logic       rx1, rx_ready1, rx_valid1, frame_err1, parity_err1, overrun1, busy1;
  logic [7:0] rx_data1;

  int vectors     = 0;
  int miscompares = 0;

  // Accepted bytes recorded as {data, frame_err, parity_err, overrun}.
  logic [10:0] q0[$];
  logic [10:0] q1[$];
  int          vhi0 = 0;

  always #5 clk = ~clk;

  uart_rx u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_ready(rx_ready0), .frame_err(frame_err0), .parity_err(parity_err0),
    .overrun(overrun0), .busy(busy0)
  );

  uart_rx #(
    .clock_rate(CLK1), .baudrate(BAUD), .PARITY_EN(1), .PARITY_ODD(0)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_ready(rx_ready1), .frame_err(frame_err1), .parity_err(parity_err1),
    .overrun(overrun1), .busy(busy1)
  );

  always @(negedge clk) begin
    if (rx_valid0) vhi0 = vhi0 + 1;
    if (rx_valid0 && rx_ready0) q0.push_back({rx_data0, frame_err0, parity_err0, overrun0});
    if (rx_valid1 && rx_ready1) q1.push_back({rx_data1, frame_err1, parity_err1, overrun1});
  end

  // Reference: what a correct receiver reports for one frame.
  function automatic logic [10:0] model_rec(input logic [7:0] b, input logic stop,
                                            input logic use_par, input logic pbit,
                                            input logic odd, input logic ov);
    int   ones;
    logic pe;
    ones = $countones(b) + int'(pbit);
    pe   = use_par ? (((ones % 2) == 1) != odd) : 1'b0;
    return {b, ~stop, pe, ov};
  endfunction

  task automatic drive_bit(input int which, input logic v, input int n);
    if (which == 0) rx0 = v;
    else            rx1 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input logic stop,
                            input logic use_par, input logic pbit);
    int n;
    n = (which == 0) ? BIT0 : BIT1;
    drive_bit(which, 1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(which, b[i], n);
    if (use_par) drive_bit(which, pbit, n);
    drive_bit(which, stop, n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rx_ready0 = 1'b1; rx_ready1 = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if ({rx_data0, rx_valid0, frame_err0, parity_err0, overrun0, busy0} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_dut0: got %h expected 0", {rx_data0, rx_valid0, frame_err0, parity_err0, overrun0, busy0});
    end
    vectors++;
    if ({rx_data1, rx_valid1, frame_err1, parity_err1, overrun1, busy1} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_dut1: got %h expected 0", {rx_data1, rx_valid1, frame_err1, parity_err1, overrun1, busy1});
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic();
    int          v_before;
    logic [10:0] got, exp;
    q0.delete();
    v_before = vhi0;
    send_frame(0, 8'h55, 1'b1, 1'b0, 1'b0);
    repeat (BIT0) @(negedge clk);
    exp = model_rec(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    got = (q0.size() > 0) ? q0[0] : 11'h7FF;
    vectors++;
    if (q0.size() !== 1) begin
      miscompares++; $display("FAIL basic_count: got %0d bytes expected 1", q0.size());
    end
    vectors++;
    if (got !== exp) begin
      miscompares++; $display("FAIL basic_rec: got %h expected %h", got, exp);
    end
    vectors++;
    if (vhi0 - v_before !== 1) begin
      miscompares++; $display("FAIL basic_pulse: rx_valid high %0d clks expected 1", vhi0 - v_before);
    end
    vectors++;
    if (busy0 !== 1'b0) begin
      miscompares++; $display("FAIL basic_busy: got %b expected 0", busy0);
    end
  endtask

  task automatic test_random();
    logic [7:0]  b;
    logic        stop;
    logic [10:0] got, exp;
    for (int k = 0; k < 3; k++) begin
      q0.delete();
      b    = 8'($urandom);
      stop = 1'($urandom_range(0, 1));
      send_frame(0, b, stop, 1'b0, 1'b0);
      drive_bit(0, 1'b1, 2 * BIT0 + int'($urandom_range(0, 50)));
      exp = model_rec(b, stop, 1'b0, 1'b0, 1'b0, 1'b0);
      got = (q0.size() == 1) ? q0[0] : 11'h7FF;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random_rec[%0d]: got %h (n=%0d) expected %h", k, got, q0.size(), exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    rx_ready0 = 1'b0;
    send_frame(0, 8'hA3, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({rx_valid0, rx_data0, frame_err0, overrun0} !== {1'b1, 8'hA3, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_first: got %h expected %h", {rx_valid0, rx_data0, frame_err0, overrun0}, {1'b1, 8'hA3, 1'b0, 1'b0});
    end
    send_frame(0, 8'h3C, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({rx_valid0, rx_data0, frame_err0, overrun0} !== {1'b1, 8'h3C, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_overrun: got %h expected %h", {rx_valid0, rx_data0, frame_err0, overrun0}, {1'b1, 8'h3C, 1'b0, 1'b1});
    end
    rx_ready0 = 1'b1;
    @(negedge clk);
    rx_ready0 = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rx_valid0, overrun0} !== 2'b00) begin
      miscompares++; $display("FAIL b2b_accept: valid/overrun got %b expected 00", {rx_valid0, overrun0});
    end
    rx_ready0 = 1'b1;
    repeat (BIT0) @(negedge clk);
  endtask

  task automatic test_glitch();
    logic saw;
    int   drop;
    q0.delete();
    saw  = 1'b0;
    drop = -1;
    rx0  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 100) rx0 = 1'b1;
      if (busy0) saw = 1'b1;
      if (saw && !busy0 && drop < 0) drop = i;
    end
    vectors++;
    if (saw !== 1'b1) begin
      miscompares++; $display("FAIL glitch_busy_rise: got %b expected 1", saw);
    end
    vectors++;
    if ((drop >= 0) !== 1'b1) begin
      miscompares++; $display("FAIL glitch_busy_drop: busy still %b after 300 clks expected 0", busy0);
    end
    repeat (1000) @(negedge clk);
    vectors++;
    if (q0.size() !== 0) begin
      miscompares++; $display("FAIL glitch_no_output: got %0d bytes expected 0", q0.size());
    end
  endtask

  task automatic test_frame_err();
    logic [10:0] got, exp;
    q0.delete();
    send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b0);
    repeat (15 * BIT0) @(negedge clk);
    exp = model_rec(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    got = (q0.size() > 0) ? q0[0] : 11'h7FF;
    vectors++;
    if (got !== exp) begin
      miscompares++; $display("FAIL frame_err_rec: got %h expected %h", got, exp);
    end
    vectors++;
    if ({q0.size() == 1, busy0} !== 2'b10) begin
      miscompares++; $display("FAIL frame_err_rearm: bytes %0d busy %b expected 1 byte busy 0", q0.size(), busy0);
    end
    drive_bit(0, 1'b1, 2 * BIT0);
  endtask

  task automatic test_reset_midframe();
    logic [7:0]  b;
    logic [10:0] got, exp;
    q0.delete();
    b = 8'($urandom);
    drive_bit(0, 1'b0, BIT0);
    for (int i = 0; i < 4; i++) drive_bit(0, b[i], BIT0);
    drive_bit(0, b[4], BIT0 / 2);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if ({rx_data0, rx_valid0, frame_err0, parity_err0, overrun0, busy0} !== 13'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %h expected 0", {rx_data0, rx_valid0, frame_err0, parity_err0, overrun0, busy0});
    end
    rx0   = 1'b1;
    rst_n = 1'b1;
    repeat (12 * BIT0) @(negedge clk);
    vectors++;
    if ({q0.size() == 0, busy0} !== 2'b10) begin
      miscompares++; $display("FAIL midreset_discard: bytes %0d busy %b expected 0 bytes busy 0", q0.size(), busy0);
    end
    send_frame(0, 8'h81, 1'b1, 1'b0, 1'b0);
    repeat (BIT0) @(negedge clk);
    exp = model_rec(8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    got = (q0.size() == 1) ? q0[0] : 11'h7FF;
    vectors++;
    if (got !== exp) begin
      miscompares++; $display("FAIL midreset_next: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_parity();
    logic [7:0]  b;
    logic        pb, stop;
    logic [10:0] got, exp;
    for (int k = 0; k < 8; k++) begin
      q1.delete();
      if (k < 2) begin
        b = 8'h07; pb = (k == 1); stop = 1'b1;
      end else begin
        b = 8'($urandom); pb = 1'($urandom_range(0, 1)); stop = 1'($urandom_range(0, 1));
      end
      send_frame(1, b, stop, 1'b1, pb);
      drive_bit(1, 1'b1, 2 * BIT1);
      exp = model_rec(b, stop, 1'b1, pb, 1'b0, 1'b0);
      got = (q1.size() == 1) ? q1[0] : 11'h7FF;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL parity_rec[%0d]: got %h (n=%0d) expected %h", k, got, q1.size(), exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, expected bench to complete");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter clock_rate, default 50000000, input clock frequency in Hz.
REQ-002 Parameter baudrate, default 115200, line bit rate in bits/s.
REQ-003 Parameter PARITY_EN, default 0, 1 = one parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
REQ-005 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port rx, input, 1, asynchronous serial line; idles high.
REQ-008 Port rx_data, output, 8, received byte, LSB received first.
REQ-009 Port rx_valid, output, 1, rx_data and the error flags are valid.
REQ-010 Port rx_ready, input, 1, consumer accepts the byte when it is high together with rx_valid.
REQ-011 Port frame_err, output, 1, sampled stop bit was 0; qualified by rx_valid.
REQ-012 Port parity_err, output, 1, parity mismatch; always 0 when PARITY_EN=0; qualified by rx_valid.
REQ-013 Port overrun, output, 1, the held byte was overwritten before acceptance; qualified by rx_valid.
REQ-014 Port busy, output, 1, high in every state except IDLE.

Function
REQ-015 Oversample tick: one-clk pulse every DIV = clock_rate/(baudrate*16) clks, integer division; DIV < 1 is a configuration error.
REQ-016 rx passes through a 2-flop synchronizer; all logic uses only the synchronized value.
REQ-017 Sample counter 0..15: advances on each tick, wraps 15->0 at the bit boundary; samples taken at counts 7, 8, 9; bit value = majority of the 3 samples, decided at count 9.
REQ-018 States: IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE: a synchronized 1->0 transition clears the tick divider and the sample counter and moves to START; a line held low never triggers a frame.
REQ-020 START: a majority of 0 continues to DATA at the next bit boundary; a majority of 1 is a glitch, returns to IDLE, and produces no output.
REQ-021 DATA: 8 bits, shifted in LSB first; after bit 7 go to PARITY if PARITY_EN=1, else go to STOP.
REQ-022 PARITY: parity_err = (XOR of data bits ^ parity bit) != PARITY_ODD.
REQ-023 STOP: at the count-9 decision, load rx_data and the flags, set frame_err = ~stop_bit, and return to IDLE in the same cycle so a next start edge is caught from mid-stop onward.
REQ-024 Latency: rx_valid rises exactly 1 clk after the stop-bit decision cycle.
REQ-025 rx_valid stays high until the first clk edge with rx_ready=1, then clears.
REQ-026 A completion while rx_valid=1 and rx_ready=0 overwrites rx_data and the flags, sets overrun=1, and keeps rx_valid=1.
REQ-027 A completion in the same cycle as an accepting handshake loads the new byte with overrun=0 and keeps rx_valid=1.
REQ-028 frame_err, parity_err and overrun clear on the handshake that accepts their byte.
REQ-029 A frame with frame_err=1 is still delivered; the receiver re-arms only on a fresh 1->0 edge.

Reset
REQ-030 rst_n low, asynchronous, forces: state=IDLE; counters=0; synchronizer flops=1; rx_data=0x00; rx_valid, frame_err, parity_err, overrun, busy=0.
REQ-031 Reset asserted mid-frame discards the partial byte; after release the receiver waits for a new falling edge.

Structure
REQ-032 Package uart_pkg holds the state enum, the OVERSAMPLE=16 constant, and a divisor function of clock_rate and baudrate.
REQ-033 The tick generator is sub-module uart_baud_tick (inputs clk, rst_n, clear; output tick); the remaining logic stays in uart_rx.

Verification
REQ-034 Defaults (DIV=27, 432 clks/bit), frame 0x55 with stop=1, rx_ready=1 -> rx_valid 1-clk pulse, rx_data=0x55, all flags 0.
REQ-035 0xA3 then 0x3C back-to-back, rx_ready=0 -> rx_data=0x3C, overrun=1; one rx_ready clk clears rx_valid and overrun.
REQ-036 rx low for 100 clks, then high -> no rx_valid, busy back to 0 by the count-9 decision of the start bit.
REQ-037 0x0F with stop bit driven 0 -> rx_data=0x0F, frame_err=1; line held low afterwards -> no further frame.
REQ-038 PARITY_EN=1, PARITY_ODD=0, byte 0x07 with parity bit 0 -> parity_err=1; same byte with parity bit 1 -> parity_err=0.
REQ-039 rst_n pulsed low during data bit 4 -> outputs at reset values; next clean frame 0x81 received correctly.
